// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory or its arbiter (slave).
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: passes ALU results through, performs loads and
// stores over a req/ack bus with timeout, and registers write-back results.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [5:0]         op,
    input  logic [31:0]        regcData,
    input  logic [31:0]        storeData,
    input  logic               regcWr_i,
    input  logic [4:0]         regcAddr_i,
    output logic               stall,
    mem_stage_if.master        bus,
    output logic               wb_valid,
    output logic [31:0]        regData,
    output logic               regWr,
    output logic [4:0]         regAddr,
    output logic [1:0]         excpt
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;

    // Op attributes latched at issue, used when the access completes
    logic [5:0]        op_p1;
    logic              wr_p1;
    logic [4:0]        dst_p1;
    logic [1:0]        lane_p1;

    logic              accept;
    logic              is_mem;
    logic              is_word;
    logic              is_store;
    logic              misaligned;
    logic              start_access;
    logic              ack_seen;
    logic              timed_out;

    function automatic logic [3:0] byte_enable(input logic [5:0] o, input logic [1:0] lo);
        logic [3:0] be;
        if (o == OP_LW || o == OP_SW)
            be = 4'b1111;
        else
            be = 4'b0001 << lo;
        return be;
    endfunction

    // Little-endian lane pick; Lb sign-extends through a signed byte.
    function automatic logic [31:0] load_extract(input logic [5:0] o, input logic [1:0] lane,
                                                 input logic [31:0] rdata);
        logic        [7:0]  b;
        logic signed [7:0]  sb;
        logic signed [31:0] sx;
        logic        [31:0] res;
        b  = rdata[{lane, 3'b000} +: 8];
        sb = signed'(b);
        sx = sb;
        case (o)
            OP_LB:   res = unsigned'(sx);
            OP_LBU:  res = {24'd0, b};
            default: res = rdata;
        endcase
        return res;
    endfunction

    always_comb begin
        is_word      = (op == OP_LW) || (op == OP_SW);
        is_store     = (op == OP_SW) || (op == OP_SB);
        is_mem       = is_word || (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
        misaligned   = is_word && (regcData[1:0] != 2'b00);
        accept       = ex_valid && !stall;
        start_access = accept && is_mem && !misaligned;
        ack_seen     = (state == WAIT) && bus.mem_ack;
        timed_out    = (state == WAIT) && !bus.mem_ack && (cnt == CNT_LAST);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_access)           state_nxt = WAIT;
            WAIT:    if (ack_seen || timed_out)  state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        stall = (state == WAIT);
    end

    // Bus request side and latched op
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            op_p1         <= '0;
            wr_p1         <= 1'b0;
            dst_p1        <= '0;
            lane_p1       <= '0;
        end else if (start_access) begin
            cnt           <= '0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= is_store;
            bus.mem_addr  <= {regcData[31:2], 2'b00};
            bus.mem_be    <= byte_enable(op, regcData[1:0]);
            bus.mem_wdata <= (op == OP_SB) ? {4{storeData[7:0]}} : storeData;
            op_p1         <= op;
            wr_p1         <= regcWr_i;
            dst_p1        <= regcAddr_i;
            lane_p1       <= regcData[1:0];
        end else if (ack_seen || timed_out) begin
            bus.mem_req   <= 1'b0;
        end else if (state == WAIT) begin
            cnt           <= cnt + 1'b1;
        end
    end

    // Write-back register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            regData  <= '0;
            regWr    <= 1'b0;
            regAddr  <= '0;
            excpt    <= EXC_NONE;
        end else begin
            wb_valid <= 1'b0;
            excpt    <= EXC_NONE;
            if (accept && !is_mem) begin
                wb_valid <= 1'b1;
                regData  <= regcData;
                regWr    <= regcWr_i;
                regAddr  <= regcAddr_i;
            end else if (accept && misaligned) begin
                wb_valid <= 1'b1;
                regWr    <= 1'b0;
                regAddr  <= regcAddr_i;
                excpt    <= EXC_MISALIGN;
            end else if (ack_seen) begin
                wb_valid <= 1'b1;
                regAddr  <= dst_p1;
                if (op_p1 == OP_SW || op_p1 == OP_SB) begin
                    regWr <= 1'b0;
                end else begin
                    regWr   <= wr_p1;
                    regData <= load_extract(op_p1, lane_p1, bus.mem_rdata);
                end
            end else if (timed_out) begin
                wb_valid <= 1'b1;
                regWr    <= 1'b0;
                regAddr  <= dst_p1;
                excpt    <= EXC_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected write-backs into a
// scoreboard queue that an independent negedge monitor drains and compares.
module tb_mem_stage;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [5:0]  op;
    logic [31:0] regcData;
    logic [31:0] storeData;
    logic        regcWr_i;
    logic [4:0]  regcAddr_i;
    logic        stall;
    logic        wb_valid;
    logic [31:0] regData;
    logic        regWr;
    logic [4:0]  regAddr;
    logic [1:0]  excpt;

    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .op         (op),
        .regcData   (regcData),
        .storeData  (storeData),
        .regcWr_i   (regcWr_i),
        .regcAddr_i (regcAddr_i),
        .stall      (stall),
        .bus        (bus),
        .wb_valid   (wb_valid),
        .regData    (regData),
        .regWr      (regWr),
        .regAddr    (regAddr),
        .excpt      (excpt)
    );

    typedef struct {
        logic [31:0] data;
        logic        wr;
        logic [4:0]  addr;
        logic [1:0]  ex;
        bit          chk_data;
        bit          chk_addr;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic push_exp(input logic [31:0] d, input logic w, input logic [4:0] a,
                            input logic [1:0] ex, input bit cd, input bit ca);
        exp_t e;
        e.data = d; e.wr = w; e.addr = a; e.ex = ex; e.chk_data = cd; e.chk_addr = ca;
        sbq.push_back(e);
    endtask

    // Called at a negedge; returns at the next negedge with ex_valid dropped.
    task automatic issue(input logic [5:0] o, input logic [31:0] d, input logic [31:0] s,
                         input logic w, input logic [4:0] a);
        ex_valid = 1'b1; op = o; regcData = d; storeData = s; regcWr_i = w; regcAddr_i = a;
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic bus_phase(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input bit chk_wdata, input int cycles,
                             input bit ack, input logic [31:0] rdata);
        for (int i = 1; i <= cycles; i++) begin
            chk("mem_req_high", 32'(bus.mem_req), 1);
            chk("stall_high", 32'(stall), 1);
            chk("mem_we", 32'(bus.mem_we), 32'(we));
            chk("mem_addr", bus.mem_addr, addr);
            chk("mem_be", 32'(bus.mem_be), 32'(be));
            if (chk_wdata) chk("mem_wdata", bus.mem_wdata, wdata);
            if (ack && i == cycles) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        chk("mem_req_drop", 32'(bus.mem_req), 0);
        chk("stall_drop", 32'(stall), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (wb_valid) begin
            if (sbq.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 0);
            end else begin
                e = sbq.pop_front();
                chk("regWr", 32'(regWr), 32'(e.wr));
                chk("excpt", 32'(excpt), 32'(e.ex));
                if (e.chk_data) chk("regData", regData, e.data);
                if (e.chk_addr) chk("regAddr", 32'(regAddr), 32'(e.addr));
            end
        end else if (excpt != 2'b00) begin
            chk("excpt_without_wb", 32'(excpt), 0);
        end
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; op = OP_NOP; regcData = '0; storeData = '0;
        regcWr_i = 1'b0; regcAddr_i = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_regData", regData, 0);
        chk("rst_regWr", 32'(regWr), 0);
        chk("rst_regAddr", 32'(regAddr), 0);
        chk("rst_excpt", 32'(excpt), 0);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_be", 32'(bus.mem_be), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_stall", 32'(stall), 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of an access, with ack held through and after it
        issue(OP_LW, 32'h0000_3000, 32'h0, 1'b1, 5'd2);
        chk("pre_rst_mem_req", 32'(bus.mem_req), 1);
        chk("pre_rst_stall", 32'(stall), 1);
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("midrst_mem_req", 32'(bus.mem_req), 0);
        chk("midrst_stall", 32'(stall), 0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_regWr", 32'(regWr), 0);
        chk("midrst_regData", regData, 0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("post_rst_mem_req", 32'(bus.mem_req), 0);
        repeat (2) @(negedge clk);

        // Back-to-back non-memory ops
        for (int i = 0; i < 3; i++) begin
            push_exp(32'h11 * (i + 1), 1'b1, 5'(5 + i), 2'b00, 1, 1);
            ex_valid = 1'b1; op = OP_NOP; regcData = 32'h11 * (i + 1);
            regcWr_i = 1'b1; regcAddr_i = 5'(5 + i);
            @(negedge clk);
            chk("nonmem_stall", 32'(stall), 0);
        end
        ex_valid = 1'b0;
        @(negedge clk);

        // Store word, ack on the third request cycle
        push_exp(32'h0, 1'b0, 5'd9, 2'b00, 0, 1);
        issue(OP_SW, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 5'd9);
        bus_phase(1'b1, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 1, 3, 1, 32'h0);

        // Aligned load word
        push_exp(32'hCAFE_F00D, 1'b1, 5'd3, 2'b00, 1, 1);
        issue(OP_LW, 32'h0000_2004, 32'h0, 1'b1, 5'd3);
        bus_phase(1'b0, 32'h0000_2004, 4'b1111, 32'h0, 0, 2, 1, 32'hCAFE_F00D);

        // Byte loads from lanes 3 and 0
        push_exp(32'hFFFF_FF80, 1'b1, 5'd10, 2'b00, 1, 1);
        issue(OP_LB, 32'h0000_2003, 32'h0, 1'b1, 5'd10);
        bus_phase(1'b0, 32'h0000_2000, 4'b1000, 32'h0, 0, 1, 1, 32'h80FF_7F01);

        push_exp(32'h0000_0080, 1'b1, 5'd11, 2'b00, 1, 1);
        issue(OP_LBU, 32'h0000_2003, 32'h0, 1'b1, 5'd11);
        bus_phase(1'b0, 32'h0000_2000, 4'b1000, 32'h0, 0, 2, 1, 32'h80FF_7F01);

        push_exp(32'h0000_0001, 1'b1, 5'd12, 2'b00, 1, 1);
        issue(OP_LB, 32'h0000_2000, 32'h0, 1'b1, 5'd12);
        bus_phase(1'b0, 32'h0000_2000, 4'b0001, 32'h0, 0, 1, 1, 32'h80FF_7F01);

        // Store byte replicates the low byte across all lanes
        push_exp(32'h0, 1'b0, 5'd13, 2'b00, 0, 1);
        issue(OP_SB, 32'h0000_2001, 32'h1234_56AB, 1'b1, 5'd13);
        bus_phase(1'b1, 32'h0000_2000, 4'b0010, 32'hABAB_ABAB, 1, 2, 1, 32'h0);

        // Misaligned word accesses never reach the bus
        push_exp(32'h0, 1'b0, 5'd4, 2'b01, 0, 0);
        issue(OP_LW, 32'h0000_1002, 32'h0, 1'b1, 5'd4);
        chk("misalign_lw_req", 32'(bus.mem_req), 0);
        chk("misalign_lw_stall", 32'(stall), 0);
        @(negedge clk);
        push_exp(32'h0, 1'b0, 5'd4, 2'b01, 0, 0);
        issue(OP_SW, 32'h0000_1001, 32'h5555_5555, 1'b1, 5'd4);
        chk("misalign_sw_req", 32'(bus.mem_req), 0);
        @(negedge clk);

        // Timeout: request stays up exactly 16 cycles
        push_exp(32'h0, 1'b0, 5'd8, 2'b10, 0, 0);
        issue(OP_LW, 32'h0000_4000, 32'h0, 1'b1, 5'd8);
        bus_phase(1'b0, 32'h0000_4000, 4'b1111, 32'h0, 0, 16, 0, 32'h0);
        @(negedge clk);

        // Ack on the final allowed cycle completes normally, then a new op right away
        push_exp(32'h55AA_55AA, 1'b1, 5'd8, 2'b00, 1, 1);
        issue(OP_LW, 32'h0000_4000, 32'h0, 1'b1, 5'd8);
        bus_phase(1'b0, 32'h0000_4000, 4'b1111, 32'h0, 0, 16, 1, 32'h55AA_55AA);
        push_exp(32'h77, 1'b1, 5'd1, 2'b00, 1, 1);
        issue(OP_NOP, 32'h77, 32'h0, 1'b1, 5'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes EX results: op, ALU result, write-back register controls, plus store data.
- Performs loads and stores over a req/ack data-memory bus and stalls upstream while an access is outstanding.
- Presents registered write-back results (data, write enable, destination) to the WB/regfile stage.

Parameters:
- TIMEOUT, 16: max cycles mem_req may stay high without mem_ack before the access is aborted (≥2).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high (`RstEnable = 1)
- ex_valid  in  1  EX result valid this cycle
- op  in  6  operation code (define.v macros `Lw, `Lb, `Lbu, `Sw, `Sb; all other codes are non-memory)
- regcData  in  32  EX result: ALU value, or effective address for loads/stores
- storeData  in  32  register value to be stored
- regcWr_i  in  1  EX write-enable
- regcAddr_i  in  5  EX destination register
- stall  out  1  upstream must hold EX outputs; input is not accepted while 1
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address ({regcData[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  access complete
- wb_valid  out  1  write-back outputs valid (one-cycle pulse per accepted op)
- regData  out  32  write-back data
- regWr  out  1  write-back enable
- regAddr  out  5  write-back register
- excpt  out  2  one-cycle pulse: 2'b01 misaligned, 2'b10 bus timeout, 2'b00 none

Behaviour:
- Reset, synchronous active-high: state=IDLE, counter=0; mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, regData, regWr, regAddr, excpt all 0.
- Reset mid-access drops mem_req on the next edge. Any later mem_ack is ignored and produces no write-back.
- FSM has two states, IDLE and WAIT. stall = (state==WAIT), combinational.
- Accept condition: ex_valid && !stall.
- Non-memory op accepted in cycle N:
  - Cycle N+1: wb_valid=1, regData=regcData, regWr=regcWr_i, regAddr=regcAddr_i.
  - State stays IDLE, so back-to-back non-memory ops flow at one per cycle.
- Load/store accepted in cycle N with aligned address:
  - Cycle N+1: state=WAIT, mem_req=1, mem_we=1 for stores, mem_addr, mem_be and mem_wdata latched. Counter=0.
  - Bus outputs hold stable until the access completes.
- Alignment:
  - `Lw/`Sw require regcData[1:0]==0.
  - Byte ops are always aligned.
- Misaligned `Lw/`Sw: no bus request. Cycle N+1: excpt=01, wb_valid=1, regWr=0. State stays IDLE.
- Byte enables:
  - Word ops: 4'b1111.
  - `Sb/`Lb/`Lbu: one-hot 1<<regcData[1:0].
  - `Sb drives mem_wdata={4{storeData[7:0]}}.
  - `Sw drives mem_wdata=storeData.
- In WAIT, mem_ack sampled 1 at cycle M:
  - Cycle M+1: mem_req=0, state=IDLE, stall=0, wb_valid=1, regAddr/regWr from the latched op.
  - Store: regWr=0.
  - Load: regWr equals the latched regcWr_i. regData is the lane-selected value below.
- Load data lane selection (little-endian, lane k = mem_rdata[8k+7:8k] with k=addr[1:0]):
  - `Lw: mem_rdata.
  - `Lb: sign-extended lane.
  - `Lbu: zero-extended lane.
- mem_ack while mem_req=0 is ignored.
- Timeout: the counter increments each WAIT cycle without ack. If ack is absent on the cycle the counter equals TIMEOUT-1:
  - Next cycle: mem_req=0, state=IDLE, excpt=10, wb_valid=1, regWr=0.
  - Ack on exactly that final cycle wins over timeout (normal completion).
- wb_valid and excpt are single-cycle pulses. Other write-back outputs hold their last value when wb_valid=0.
- Completion cycle M+1 has stall=0, so a new op may be accepted in M+1. Throughput for memory ops is one per (ack latency + 2) cycles.

Test Plan:
- Reset: rst=1 for 2 cycles during WAIT with mem_ack=1 -> all outputs 0, no wb_valid pulse after release.
- Non-memory back-to-back: three ops with regcData=0x11,0x22,0x33, regcWr_i=1, regcAddr_i=5,6,7 in consecutive cycles -> wb_valid high 3 cycles, regData 0x11/0x22/0x33 one cycle later each, stall never 1.
- Store word: `Sw addr 0x1000, storeData 0xDEADBEEF, ack after 3 cycles -> mem_req=1 with we=1, be=1111, wdata 0xDEADBEEF for 3 cycles; stall=1 throughout; wb_valid with regWr=0 after ack.
- Byte loads: mem_rdata=0x80FF7F01 at addr 0x2003 (`Lb) -> regData 0xFFFFFF80. `Lbu at addr 0x2003 -> 0x00000080. `Lb at addr 0x2000 -> 0x00000001, with be=0001 for the 0x2000 access.
- Misaligned: `Lw addr 0x1002 -> no mem_req, excpt=01 pulse, wb_valid=1, regWr=0.
- Timeout: TIMEOUT=16, no ack -> mem_req high exactly 16 cycles, then excpt=10, regWr=0, stall drops. Repeat with ack on cycle 16 -> normal completion, excpt=00.
